// File: rtl/sd_channel_scheduler.sv
// sd_channel_scheduler
//   Lets two symbol producers take turns on one external sequence detector.
//   A grant lasts for up to BURST symbols. The detector is cleared between
//   bursts, and the match count of each burst is added to a saturating
//   per-requester hit counter.
//
//   Handshake: a symbol moves on requester N when validN && readyN are both
//   high at a rising clock edge. readyN is combinational and can only be
//   high in FEED, for the current owner, while beats < BURST. The producer
//   must hold symN stable while validN is high. If the producer drops validN
//   without a transfer, the burst ends.
//
//   Optional build macro: SD_STRICT_PRIO_EN. When it is defined, requester 0
//   wins every arbitration in which it is valid. When it is not defined,
//   arbitration is round-robin on last_owner.
//
//   Ports:
//     clock, reset_        clock; synchronous active-low reset
//     sym0/valid0/ready0   requester 0 symbol stream
//     sym1/valid1/ready1   requester 1 symbol stream
//     det_x1_x0            symbol to detector (pad 01 when idle)
//     det_reset_           registered detector reset, active-low
//     det_z3_z0            detector match count
//     owner                current or last grant holder
//     busy                 FSM is not in IDLE
//     hit0, hit1           saturating accumulated match counts
module sd_channel_scheduler #(
  parameter int BURST = 12,
  parameter int CW    = 8
) (
  input  logic          clock,
  input  logic          reset_,
  input  logic [1:0]    sym0,
  input  logic          valid0,
  output logic          ready0,
  input  logic [1:0]    sym1,
  input  logic          valid1,
  output logic          ready1,
  output logic [1:0]    det_x1_x0,
  output logic          det_reset_,
  input  logic [3:0]    det_z3_z0,
  output logic          owner,
  output logic          busy,
  output logic [CW-1:0] hit0,
  output logic [CW-1:0] hit1
);

  localparam int BW = $clog2(BURST + 1);
  // The sum must be wide enough to hold a 4-bit detector count, even when CW < 4.
  localparam int SW = ((CW > 4) ? CW : 4) + 1;
  localparam logic [BW-1:0] BURST_C = BW'(BURST);
  localparam logic [SW-1:0] HIT_MAX = {{(SW-CW){1'b0}}, {CW{1'b1}}};
  // Pattern 01 never advances the detector count, so driving it is harmless.
  localparam logic [1:0]    PAD     = 2'b01;

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_COLLECT} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_owner, w_owner_nxt;
  logic [BW-1:0]   r_beats, w_beats_nxt;
  logic            r_det_reset_, w_det_reset_nxt;
  logic [CW-1:0]   r_hit0, w_hit0_nxt;
  logic [CW-1:0]   r_hit1, w_hit1_nxt;
  logic            w_win;
  logic            w_valid_own;
  logic [1:0]      w_sym_own;
  logic            w_room;
  logic [CW-1:0]   w_hit_own;
  logic [SW-1:0]   w_sum;
  logic [CW-1:0]   w_hit_sat;

`ifdef SD_STRICT_PRIO_EN
  assign w_win = valid0 ? 1'b0 : 1'b1;
`else
  logic            r_last_owner, w_last_owner_nxt;
  // When both requesters are valid, the one that did not hold the last grant wins.
  assign w_win = (valid0 && valid1) ? ~r_last_owner : valid1;
`endif

  assign w_valid_own = r_owner ? valid1 : valid0;
  assign w_sym_own   = r_owner ? sym1 : sym0;
  assign w_room      = (r_beats < BURST_C);
  assign w_hit_own   = r_owner ? r_hit1 : r_hit0;
  assign w_sum       = SW'(w_hit_own) + SW'(det_z3_z0);
  assign w_hit_sat   = (w_sum > HIT_MAX) ? HIT_MAX[CW-1:0] : w_sum[CW-1:0];

  always_comb begin
    w_state_nxt     = r_state;
    w_owner_nxt     = r_owner;
    w_beats_nxt     = r_beats;
    w_det_reset_nxt = r_det_reset_;
    w_hit0_nxt      = r_hit0;
    w_hit1_nxt      = r_hit1;
`ifndef SD_STRICT_PRIO_EN
    w_last_owner_nxt = r_last_owner;
`endif
    ready0    = 1'b0;
    ready1    = 1'b0;
    det_x1_x0 = PAD;
    case (r_state)
      S_IDLE: begin
        if (valid0 || valid1) begin
          w_owner_nxt     = w_win;
          w_beats_nxt     = '0;
          w_det_reset_nxt = 1'b1;
          w_state_nxt     = S_FEED;
        end
      end
      S_FEED: begin
        ready0 = ~r_owner & w_room;
        ready1 =  r_owner & w_room;
        if (w_room && w_valid_own) begin
          det_x1_x0   = w_sym_own;
          w_beats_nxt = r_beats + 1'b1;
        end else begin
          // A stall or a full burst ends the grant. This cycle drives the pad.
          w_state_nxt = S_COLLECT;
        end
      end
      S_COLLECT: begin
        // After the last transfer and the pad, det_z3_z0 holds the final count for this burst.
        if (r_owner) w_hit1_nxt = w_hit_sat;
        else         w_hit0_nxt = w_hit_sat;
        w_det_reset_nxt = 1'b0;
`ifndef SD_STRICT_PRIO_EN
        w_last_owner_nxt = r_owner;
`endif
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_beats      <= '0;
      r_det_reset_ <= 1'b0;
      r_hit0       <= '0;
      r_hit1       <= '0;
`ifndef SD_STRICT_PRIO_EN
      r_last_owner <= 1'b1;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_beats      <= w_beats_nxt;
      r_det_reset_ <= w_det_reset_nxt;
      r_hit0       <= w_hit0_nxt;
      r_hit1       <= w_hit1_nxt;
`ifndef SD_STRICT_PRIO_EN
      r_last_owner <= w_last_owner_nxt;
`endif
    end
  end

  assign det_reset_ = r_det_reset_;
  assign owner      = r_owner;
  assign busy       = (r_state != S_IDLE);
  assign hit0       = r_hit0;
  assign hit1       = r_hit1;

endmodule

// File: tb/tb_sd_channel_scheduler.sv
// Bench for sd_channel_scheduler, built with BURST=3 and CW=2 so that bursts split and hit counters saturate.
// The detector model counts each occurrence of the pair 01 followed by 10 and clears while det_reset_ is low.
module tb_sd_channel_scheduler;
  localparam int BURST = 3;
  localparam int CW    = 2;

  logic          clock = 1'b0;
  logic          reset_;
  logic [1:0]    sym0, sym1;
  logic          valid0, valid1;
  logic          ready0, ready1;
  logic [1:0]    det_x1_x0;
  logic          det_reset_;
  logic [3:0]    det_z3_z0;
  logic          owner, busy;
  logic [CW-1:0] hit0, hit1;

  always #5 clock = ~clock;

  sd_channel_scheduler #(.BURST(BURST), .CW(CW)) u_dut (
    .clock(clock), .reset_(reset_),
    .sym0(sym0), .valid0(valid0), .ready0(ready0),
    .sym1(sym1), .valid1(valid1), .ready1(ready1),
    .det_x1_x0(det_x1_x0), .det_reset_(det_reset_), .det_z3_z0(det_z3_z0),
    .owner(owner), .busy(busy), .hit0(hit0), .hit1(hit1)
  );

  // detector model
  logic [3:0] det_cnt = '0;
  logic [1:0] det_prev = '0;
  always @(posedge clock) begin
    if (!det_reset_) begin
      det_cnt  <= '0;
      det_prev <= 2'b00;
    end else begin
      if (det_prev == 2'b01 && det_x1_x0 == 2'b10 && det_cnt != 4'hF) det_cnt <= det_cnt + 4'd1;
      det_prev <= det_x1_x0;
    end
  end
  assign det_z3_z0 = det_cnt;

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  int xfer_cnt = 0;
  logic [2:0]    exp_q[$];   // {requester, symbol} in the order the detector must see them
  logic [2*CW:0] hit_q[$];   // {owner, hit0, hit1} when each burst ends
  logic [2:0]    q0[$];      // stimulus: {gap, symbol}
  logic [2:0]    q1[$];

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push0(input logic [1:0] s);
    q0.push_back({1'b0, s});
    exp_q.push_back({1'b0, s});
  endtask
  task automatic push1(input logic [1:0] s);
    q1.push_back({1'b0, s});
    exp_q.push_back({1'b1, s});
  endtask
  task automatic exp_hit(input logic o, input logic [CW-1:0] h0, input logic [CW-1:0] h1);
    hit_q.push_back({o, h0, h1});
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((hit_q.size() != 0 || exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0) && n < 300) begin
      @(negedge clock);
      n++;
    end
    check_eq("drain_in_time", 32'(n < 300), 32'd1);
    @(negedge clock);
  endtask

  // driver, requester 0
  logic fire0, gap0;
  initial begin
    valid0 = 1'b0; sym0 = 2'b00; gap0 = 1'b0;
    forever begin
      @(negedge clock);
      fire0 = valid0 && ready0;
      @(posedge clock);
      #1;
      if (q0.size() > 0 && (fire0 || gap0)) void'(q0.pop_front());
      gap0 = 1'b0;
      if (q0.size() > 0) begin
        if (q0[0][2]) begin valid0 = 1'b0; gap0 = 1'b1; end
        else begin valid0 = 1'b1; sym0 = q0[0][1:0]; end
      end else valid0 = 1'b0;
    end
  end

  // driver, requester 1
  logic fire1, gap1;
  initial begin
    valid1 = 1'b0; sym1 = 2'b00; gap1 = 1'b0;
    forever begin
      @(negedge clock);
      fire1 = valid1 && ready1;
      @(posedge clock);
      #1;
      if (q1.size() > 0 && (fire1 || gap1)) void'(q1.pop_front());
      gap1 = 1'b0;
      if (q1.size() > 0) begin
        if (q1[0][2]) begin valid1 = 1'b0; gap1 = 1'b1; end
        else begin valid1 = 1'b1; sym1 = q1[0][1:0]; end
      end else valid1 = 1'b0;
    end
  end

  // monitor
  logic prev_busy = 1'b0;
  logic x0, x1;
  logic [2:0] e_sym;
  logic [2*CW:0] e_hit;
  initial begin
    forever begin
      @(negedge clock);
      x0 = ready0 && valid0;
      x1 = ready1 && valid1;
      if (reset_) begin
        if (ready0 || ready1) check_eq("ready_exclusive", 32'(ready0 && ready1), 32'd0);
        if (x0 || x1) begin
          xfer_cnt++;
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL xfer_unexpected actual=%0h expected=none t=%0t", {x1, det_x1_x0}, $time);
          end else begin
            e_sym = exp_q.pop_front();
            check_eq("xfer_symbol", 32'({x1, det_x1_x0}), 32'(e_sym));
          end
        end else check_eq("pad_symbol", 32'(det_x1_x0), 32'h1);
      end
      if (prev_busy && !busy) begin
        if (hit_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL burst_unexpected actual=%0h expected=none t=%0t", {owner, hit0, hit1}, $time);
        end else begin
          e_hit = hit_q.pop_front();
          check_eq("burst_hits", 32'({owner, hit0, hit1}), 32'(e_hit));
        end
        check_eq("det_reset_idle", 32'(det_reset_), 32'd0);
      end
      prev_busy = busy;
    end
  end

  initial begin
    int n;
    int base;
    reset_ = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_eq("rst_ready0", 32'(ready0), 32'd0);
    check_eq("rst_ready1", 32'(ready1), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_det_sym", 32'(det_x1_x0), 32'h1);
    check_eq("rst_det_reset", 32'(det_reset_), 32'd0);
    check_eq("rst_owner", 32'(owner), 32'd0);
    check_eq("rst_hit0", 32'(hit0), 32'd0);
    check_eq("rst_hit1", 32'(hit1), 32'd0);
    @(posedge clock); #2 reset_ = 1'b1;
    @(negedge clock);

    // single requester, short burst 01,10 -> one match
    push0(2'b01); push0(2'b10);
    exp_hit(1'b0, 2'd1, 2'd0);
    wait_drain();

    // burst limit: 6 symbols split into two bursts of 3, one match each
    push0(2'b00); push0(2'b01); push0(2'b10); push0(2'b11); push0(2'b01); push0(2'b10);
    exp_hit(1'b0, 2'd2, 2'd0);
    exp_hit(1'b0, 2'd3, 2'd0);
    wait_drain();

    // saturation: another matching burst leaves hit0 at 3
    push0(2'b01); push0(2'b10);
    exp_hit(1'b0, 2'd3, 2'd0);
    wait_drain();

    // stall: 00,01 | gap | 10; the cleared detector sees no match
    push1(2'b00); push1(2'b01); q1.push_back(3'b100); push1(2'b10);
    exp_hit(1'b1, 2'd3, 2'd0);
    exp_hit(1'b1, 2'd3, 2'd0);
    wait_drain();

    // simultaneous requests, last_owner=1 -> requester 0 first
    push0(2'b00); push0(2'b01); push0(2'b10);
    push1(2'b00); push1(2'b01); push1(2'b10);
    exp_hit(1'b0, 2'd3, 2'd0);
    exp_hit(1'b1, 2'd3, 2'd1);
    wait_drain();

    // requester 0 alone, then both valid with last_owner=0
    push0(2'b00);
    exp_hit(1'b0, 2'd3, 2'd1);
    wait_drain();
`ifdef SD_STRICT_PRIO_EN
    push0(2'b01); push0(2'b10);
    push1(2'b01); push1(2'b10);
    exp_hit(1'b0, 2'd3, 2'd1);
    exp_hit(1'b1, 2'd3, 2'd2);
`else
    push1(2'b01); push1(2'b10);
    push0(2'b01); push0(2'b10);
    exp_hit(1'b1, 2'd3, 2'd2);
    exp_hit(1'b0, 2'd3, 2'd2);
`endif
    wait_drain();

    // reset mid-burst after two transfers
    q0.push_back(3'b000); q0.push_back(3'b001); q0.push_back(3'b010); q0.push_back(3'b011);
    exp_q.push_back(3'b000); exp_q.push_back(3'b001);
    exp_hit(1'b0, 2'd0, 2'd0);
    base = xfer_cnt;
    n = 0;
    while (xfer_cnt < base + 2 && n < 100) begin
      @(posedge clock);
      n++;
    end
    check_eq("midburst_in_time", 32'(n < 100), 32'd1);
    #2;
    reset_ = 1'b0;
    q0.delete();
    valid0 = 1'b0;
    @(posedge clock); #2 reset_ = 1'b1;
    @(negedge clock);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_det_reset", 32'(det_reset_), 32'd0);
    check_eq("mid_rst_hit0", 32'(hit0), 32'd0);
    check_eq("mid_rst_hit1", 32'(hit1), 32'd0);
    check_eq("mid_rst_ready0", 32'(ready0), 32'd0);
    check_eq("mid_rst_ready1", 32'(ready1), 32'd0);
    wait_drain();

    check_eq("exp_q_left", 32'(exp_q.size()), 32'd0);
    check_eq("hit_q_left", 32'(hit_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
